nor_bus_ctrl: RTL and testbench

Wishbone-classic slave that turns single 16-bit word requests into timed asynchronous parallel-NOR read/write cycles. It sits directly upstream of the FPGA pad ring. It drives the NOR address, data, CE#, OE# and WE# lines and samples DQ and RY/BY#. Its master is the QSPI-to-Wishbone command logic inside the core. All strobe timing comes from parameterised cycle counts at the system clock.

---
 rtl/nor_bus_ctrl.sv | 172 +++++++++++++++++
 tb/tb_nor_bus_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nor_bus_ctrl.sv
// Wishbone-classic slave that runs timed asynchronous parallel-NOR word read/write cycles.
// Optional NOR_RYBY_WAIT_EN: hold off new requests while the synchronised RY/BY# reports busy.
module nor_bus_ctrl #(
  parameter int unsigned ADDR_W     = 26,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_ack_o,
  output logic [ADDR_W-1:0] nor_addr_o,
  output logic [DATA_W-1:0] nor_data_o,
  output logic              nor_data_oe,
  input  logic [DATA_W-1:0] nor_data_i,
  output logic              nor_ce_o,
  output logic              nor_oe_o,
  output logic              nor_we_o,
  input  logic              nor_ry_i,
  output logic              nor_ready_o
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] STROBE = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);

  logic [2:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic              isWrite_q, isWrite_d;
  logic              ce_q, ce_d;
  logic              oe_q, oe_d;
  logic              we_q, we_d;
  logic              doe_q, doe_d;
  logic              ack_q, ack_d;
  logic              ryMeta_q, rySync_q;
  logic              reqOk;

`ifdef NOR_RYBY_WAIT_EN
  assign reqOk = wb_cyc_i & wb_stb_i & rySync_q;
`else
  assign reqOk = wb_cyc_i & wb_stb_i;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    rdat_d    = rdat_q;
    isWrite_d = isWrite_q;
    ce_d      = ce_q;
    oe_d      = oe_q;
    we_d      = we_q;
    doe_d     = doe_q;
    ack_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (reqOk) begin
          addr_d    = wb_adr_i;
          wdat_d    = wb_dat_i;
          isWrite_d = wb_we_i;
          ce_d      = 1'b0;
          doe_d     = wb_we_i;
          cnt_d     = SETUP_LD;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == 8'd0) begin
          if (isWrite_q) we_d = 1'b0;
          else           oe_d = 1'b0;
          cnt_d   = STROBE_LD;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      STROBE: begin
        // Read data is sampled on the same edge that releases OE#.
        if (cnt_q == 8'd0) begin
          oe_d = 1'b1;
          we_d = 1'b1;
          if (!isWrite_q) rdat_d = nor_data_i;
          cnt_d   = HOLD_LD;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          ce_d    = 1'b1;
          doe_d   = 1'b0;
          ack_d   = wb_cyc_i;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        ce_d    = 1'b1;
        oe_d    = 1'b1;
        we_d    = 1'b1;
        doe_d   = 1'b0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      addr_q    <= '0;
      wdat_q    <= '0;
      rdat_q    <= '0;
      isWrite_q <= 1'b0;
      ce_q      <= 1'b1;
      oe_q      <= 1'b1;
      we_q      <= 1'b1;
      doe_q     <= 1'b0;
      ack_q     <= 1'b0;
      ryMeta_q  <= 1'b0;
      rySync_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
      rdat_q    <= rdat_d;
      isWrite_q <= isWrite_d;
      ce_q      <= ce_d;
      oe_q      <= oe_d;
      we_q      <= we_d;
      doe_q     <= doe_d;
      ack_q     <= ack_d;
      ryMeta_q  <= nor_ry_i;
      rySync_q  <= ryMeta_q;
    end
  end

  assign wb_dat_o    = rdat_q;
  assign wb_ack_o    = ack_q;
  assign nor_addr_o  = addr_q;
  assign nor_data_o  = wdat_q;
  assign nor_data_oe = doe_q;
  assign nor_ce_o    = ce_q;
  assign nor_oe_o    = oe_q;
  assign nor_we_o    = we_q;
  assign nor_ready_o = rySync_q;

endmodule

// File: tb/tb_nor_bus_ctrl.sv
// Directed self-checking bench for nor_bus_ctrl with default timing (setup 2, strobe 4, hold 1).
// Strobe traces are packed one bit per sampled edge, bit k = value just after the k-th edge.
module tb_nor_bus_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [25:0] wb_adr_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_ack_o;
  logic [25:0] nor_addr_o;
  logic [15:0] nor_data_o;
  logic        nor_data_oe;
  logic [15:0] nor_data_i;
  logic        nor_ce_o, nor_oe_o, nor_we_o;
  logic        nor_ry_i;
  logic        nor_ready_o;

  int compared   = 0;
  int mismatched = 0;

  logic [39:0] ceS, oeS, weS, doeS, ackS;
  int          busErr;
  int          dropCycAt;
  logic        chainWrite;
  logic [25:0] expAdr, nextAdr;
  logic [15:0] expDat, nextDat;

  nor_bus_ctrl dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .nor_addr_o(nor_addr_o), .nor_data_o(nor_data_o), .nor_data_oe(nor_data_oe),
    .nor_data_i(nor_data_i), .nor_ce_o(nor_ce_o), .nor_oe_o(nor_oe_o), .nor_we_o(nor_we_o),
    .nor_ry_i(nor_ry_i), .nor_ready_o(nor_ready_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic request(input logic we, input logic [25:0] adr, input logic [15:0] dat);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    expAdr   = adr;
    expDat   = dat;
  endtask

  // Runs n edges; first edge is expected to accept the presented request.
  task automatic observe(input int n);
    ceS = '0; oeS = '0; weS = '0; doeS = '0; ackS = '0;
    busErr = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      ceS[k]  = nor_ce_o;
      oeS[k]  = nor_oe_o;
      weS[k]  = nor_we_o;
      doeS[k] = nor_data_oe;
      ackS[k] = wb_ack_o;
      if (!nor_oe_o && !nor_we_o) busErr++;
      if (nor_data_oe && !nor_oe_o) busErr++;
      if (!nor_ce_o && nor_addr_o !== expAdr) busErr++;
      if (nor_data_oe && nor_data_o !== expDat) busErr++;
      if (k == dropCycAt) begin
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
      end
      if (wb_ack_o) begin
        if (chainWrite) begin
          request(1'b1, nextAdr, nextDat);
          chainWrite = 1'b0;
        end else begin
          wb_cyc_i = 1'b0;
          wb_stb_i = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    tick(); tick();
    compared++; if (nor_ce_o !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_ce got %b want 1", nor_ce_o); end
    compared++; if (nor_oe_o !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_oe got %b want 1", nor_oe_o); end
    compared++; if (nor_we_o !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_we got %b want 1", nor_we_o); end
    compared++; if (nor_data_oe !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_doe got %b want 0", nor_data_oe); end
    compared++; if (wb_ack_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ack got %b want 0", wb_ack_o); end
    compared++; if (nor_addr_o !== 26'd0 || nor_data_o !== 16'd0 || wb_dat_o !== 16'd0) begin
      mismatched++; $display("[TB] FAIL reset_buses got addr %h data %h rdat %h want 0", nor_addr_o, nor_data_o, wb_dat_o); end
    compared++; if (nor_ready_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ready got %b want 0", nor_ready_o); end
    reset_i = 1'b0;
    tick(); tick();
  endtask

  task automatic test_read();
    nor_data_i = 16'hBEEF;
    request(1'b0, 26'h2A5A5A5, 16'h0000);
    observe(10);
    compared++; if (ceS !== 40'h380) begin mismatched++; $display("[TB] FAIL read_ce got %h want %h", ceS, 40'h380); end
    compared++; if (oeS !== 40'h3C3) begin mismatched++; $display("[TB] FAIL read_oe got %h want %h", oeS, 40'h3C3); end
    compared++; if (weS !== 40'h3FF) begin mismatched++; $display("[TB] FAIL read_we got %h want %h", weS, 40'h3FF); end
    compared++; if (ackS !== 40'h080) begin mismatched++; $display("[TB] FAIL read_ack got %h want %h", ackS, 40'h080); end
    compared++; if (doeS !== 40'h0) begin mismatched++; $display("[TB] FAIL read_doe got %h want 0", doeS); end
    compared++; if (busErr !== 0) begin mismatched++; $display("[TB] FAIL read_bus got %0d errors want 0", busErr); end
    compared++; if (wb_dat_o !== 16'hBEEF) begin mismatched++; $display("[TB] FAIL read_data got %h want beef", wb_dat_o); end
    nor_data_i = 16'h1234;
    tick(); tick(); tick();
    compared++; if (wb_dat_o !== 16'hBEEF) begin mismatched++; $display("[TB] FAIL read_hold got %h want beef", wb_dat_o); end
  endtask

  task automatic test_write();
    request(1'b1, 26'h0000555, 16'h00AA);
    observe(10);
    compared++; if (ceS !== 40'h380) begin mismatched++; $display("[TB] FAIL write_ce got %h want %h", ceS, 40'h380); end
    compared++; if (weS !== 40'h3C3) begin mismatched++; $display("[TB] FAIL write_we got %h want %h", weS, 40'h3C3); end
    compared++; if (oeS !== 40'h3FF) begin mismatched++; $display("[TB] FAIL write_oe got %h want %h", oeS, 40'h3FF); end
    compared++; if (doeS !== 40'h07F) begin mismatched++; $display("[TB] FAIL write_doe got %h want %h", doeS, 40'h07F); end
    compared++; if (ackS !== 40'h080) begin mismatched++; $display("[TB] FAIL write_ack got %h want %h", ackS, 40'h080); end
    compared++; if (busErr !== 0) begin mismatched++; $display("[TB] FAIL write_bus got %0d errors want 0", busErr); end
    compared++; if (wb_dat_o !== 16'hBEEF) begin mismatched++; $display("[TB] FAIL write_rdat got %h want beef", wb_dat_o); end
  endtask

  task automatic test_back_to_back();
    nor_data_i = 16'h5A5A;
    nextAdr    = 26'h1234567;
    nextDat    = 16'hC3C3;
    chainWrite = 1'b1;
    request(1'b0, 26'h0ABCDEF, 16'h0000);
    observe(20);
    compared++; if (ceS !== 40'hF0180) begin mismatched++; $display("[TB] FAIL b2b_ce got %h want %h", ceS, 40'hF0180); end
    compared++; if (oeS !== 40'hFFFC3) begin mismatched++; $display("[TB] FAIL b2b_oe got %h want %h", oeS, 40'hFFFC3); end
    compared++; if (weS !== 40'hF87FF) begin mismatched++; $display("[TB] FAIL b2b_we got %h want %h", weS, 40'hF87FF); end
    compared++; if (doeS !== 40'h0FE00) begin mismatched++; $display("[TB] FAIL b2b_doe got %h want %h", doeS, 40'h0FE00); end
    compared++; if (ackS !== 40'h10080) begin mismatched++; $display("[TB] FAIL b2b_ack got %h want %h", ackS, 40'h10080); end
    compared++; if (busErr !== 0) begin mismatched++; $display("[TB] FAIL b2b_bus got %0d errors want 0", busErr); end
    compared++; if (wb_dat_o !== 16'h5A5A) begin mismatched++; $display("[TB] FAIL b2b_rdat got %h want 5a5a", wb_dat_o); end
  endtask

  task automatic test_cyc_drop();
    nor_data_i = 16'h1357;
    dropCycAt  = 3;
    request(1'b0, 26'h0000100, 16'h0000);
    observe(10);
    dropCycAt  = -1;
    compared++; if (ceS !== 40'h380) begin mismatched++; $display("[TB] FAIL drop_ce got %h want %h", ceS, 40'h380); end
    compared++; if (oeS !== 40'h3C3) begin mismatched++; $display("[TB] FAIL drop_oe got %h want %h", oeS, 40'h3C3); end
    compared++; if (ackS !== 40'h0) begin mismatched++; $display("[TB] FAIL drop_ack got %h want 0", ackS); end
    compared++; if (wb_dat_o !== 16'h1357) begin mismatched++; $display("[TB] FAIL drop_rdat got %h want 1357", wb_dat_o); end
    request(1'b1, 26'h0000200, 16'h0F0F);
    observe(10);
    compared++; if (ackS !== 40'h080 || weS !== 40'h3C3) begin
      mismatched++; $display("[TB] FAIL drop_next got ack %h we %h want 080 3c3", ackS, weS); end
  endtask

  task automatic test_reset_in_setup();
    request(1'b1, 26'h3FFFFFF, 16'hFFFF);
    tick();
    compared++; if (nor_ce_o !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_accept_ce got %b want 0", nor_ce_o); end
    tick();
    reset_i  = 1'b1;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    tick();
    compared++; if ({nor_ce_o, nor_oe_o, nor_we_o, nor_data_oe, wb_ack_o} !== 5'b11100) begin
      mismatched++; $display("[TB] FAIL rst_setup_strobes got %b want 11100", {nor_ce_o, nor_oe_o, nor_we_o, nor_data_oe, wb_ack_o}); end
    compared++; if (nor_addr_o !== 26'd0 || nor_data_o !== 16'd0) begin
      mismatched++; $display("[TB] FAIL rst_setup_buses got %h %h want 0 0", nor_addr_o, nor_data_o); end
    reset_i = 1'b0;
    tick(); tick();
    nor_data_i = 16'hA5C3;
    request(1'b0, 26'h0000042, 16'h0000);
    observe(10);
    compared++; if (ackS !== 40'h080 || oeS !== 40'h3C3 || ceS !== 40'h380) begin
      mismatched++; $display("[TB] FAIL rst_recover got ack %h oe %h ce %h want 080 3c3 380", ackS, oeS, ceS); end
    compared++; if (wb_dat_o !== 16'hA5C3) begin mismatched++; $display("[TB] FAIL rst_recover_rdat got %h want a5c3", wb_dat_o); end
  endtask

  task automatic test_ready_sync();
    nor_ry_i = 1'b0;
    tick(); tick(); tick();
    compared++; if (nor_ready_o !== 1'b0) begin mismatched++; $display("[TB] FAIL ready_low got %b want 0", nor_ready_o); end
    nor_ry_i = 1'b1;
    tick();
    compared++; if (nor_ready_o !== 1'b0) begin mismatched++; $display("[TB] FAIL ready_edge1 got %b want 0", nor_ready_o); end
    tick();
    compared++; if (nor_ready_o !== 1'b1) begin mismatched++; $display("[TB] FAIL ready_edge2 got %b want 1", nor_ready_o); end
  endtask

`ifdef NOR_RYBY_WAIT_EN
  task automatic test_ryby_wait();
    int ceLowCnt;
    nor_ry_i = 1'b0;
    tick(); tick(); tick();
    request(1'b0, 26'h0000321, 16'h0000);
    ceLowCnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (nor_ce_o !== 1'b1) ceLowCnt++;
    end
    compared++; if (ceLowCnt !== 0) begin mismatched++; $display("[TB] FAIL busy_ce got %0d active cycles want 0", ceLowCnt); end
    nor_ry_i = 1'b1;
    tick(); tick();
    compared++; if (nor_ce_o !== 1'b1) begin mismatched++; $display("[TB] FAIL busy_early got ce %b want 1", nor_ce_o); end
    tick();
    compared++; if (nor_ce_o !== 1'b0) begin mismatched++; $display("[TB] FAIL busy_release got ce %b want 0", nor_ce_o); end
    observe(10);
    compared++; if (ackS !== 40'h040) begin mismatched++; $display("[TB] FAIL busy_ack got %h want 040", ackS); end
  endtask
`endif

  initial begin
    reset_i    = 1'b1;
    wb_cyc_i   = 1'b0;
    wb_stb_i   = 1'b0;
    wb_we_i    = 1'b0;
    wb_adr_i   = '0;
    wb_dat_i   = '0;
    nor_data_i = '0;
    nor_ry_i   = 1'b1;
    dropCycAt  = -1;
    chainWrite = 1'b0;
    expAdr     = '0;
    expDat     = '0;
    nextAdr    = '0;
    nextDat    = '0;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_cyc_drop();
    test_reset_in_setup();
    test_ready_sync();
`ifdef NOR_RYBY_WAIT_EN
    test_ryby_wait();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
